// File: rtl/my_top_level_pkg.sv
// Shared constants for the two-stage registered modular adder.
// Imported by the top and its add stage so the default width lives in one place.
package my_top_level_pkg;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic RESET_ACTIVE  = 1'b0;

endpackage : my_top_level_pkg

// File: rtl/my_top_level_add_stage.sv
// Single registered WIDTH-bit modular add with asynchronous active-low clear.
// The carry-out is dropped on purpose; results wrap modulo 2^WIDTH.
module my_top_level_add_stage
    import my_top_level_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] x
);

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    always_comb begin
        sum_d = a + b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign x = sum_q;

endmodule : my_top_level_add_stage

// File: rtl/my_top_level.sv
// Two-stage pipelined unsigned adder: operand registers feed a registered add.
// io_X comes straight from the add-stage flop, so it never glitches between edges.
module my_top_level
    import my_top_level_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        a_d = io_A;
        b_d = io_B;
    end

    // Clearing the operand stage too guarantees no pre-reset sum survives release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    my_top_level_add_stage #(
        .WIDTH (WIDTH)
    ) u_add_stage (
        .clk   (clk),
        .reset (reset),
        .a     (a_q),
        .b     (b_q),
        .x     (io_X)
    );

endmodule : my_top_level

// File: tb/tb_my_top_level.sv
// Directed bench for the two-stage adder: reset behaviour, latency, wrap-around,
// streaming throughput, mid-stream reset and between-edge input changes.
module tb_my_top_level;

    localparam int W = 8;

    logic         clk;
    logic         clk_en;
    logic         reset;
    logic [W-1:0] io_A;
    logic [W-1:0] io_B;
    logic [W-1:0] io_X;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] x;
    } vec_t;

    vec_t vecs[12];

    my_top_level #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io_A  (io_A),
        .io_B  (io_B),
        .io_X  (io_X)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, io_X=%0d required completion", io_X);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [W-1:0] exp);
        checks++;
        if (io_X !== exp) begin
            errors++;
            $display("FAIL %s: io_X=%0d required %0d (t=%0t)", name, io_X, exp, $time);
        end else begin
            $display("ok   %s: io_X=%0d (t=%0t)", name, io_X, $time);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{a: 8'd200, b: 8'd100, x: 8'd44};
        vecs[1]  = '{a: 8'd255, b: 8'd1,   x: 8'd0};
        vecs[2]  = '{a: 8'd255, b: 8'd255, x: 8'd254};
        vecs[3]  = '{a: 8'd1,   b: 8'd1,   x: 8'd2};
        vecs[4]  = '{a: 8'd2,   b: 8'd2,   x: 8'd4};
        vecs[5]  = '{a: 8'd3,   b: 8'd3,   x: 8'd6};
        vecs[6]  = '{a: 8'd4,   b: 8'd4,   x: 8'd8};
        vecs[7]  = '{a: 8'd128, b: 8'd128, x: 8'd0};
        vecs[8]  = '{a: 8'hAA,  b: 8'h55,  x: 8'hFF};
        vecs[9]  = '{a: 8'd17,  b: 8'd0,   x: 8'd17};
        vecs[10] = '{a: 8'd0,   b: 8'd0,   x: 8'd0};
        vecs[11] = '{a: 8'd99,  b: 8'd57,  x: 8'd156};

        // Reset asserted with the clock stopped: clear must be asynchronous.
        clk_en = 1'b0;
        reset  = 1'b1;
        io_A   = 8'h12;
        io_B   = 8'h34;
        #2;
        reset = 1'b0;
        #1;
        check("async_clear_clk_stopped", 8'h00);
        #200;
        check("hold_clear_clk_stopped", 8'h00);

        // Clock running while held in reset.
        clk_en = 1'b1;
        repeat (3) edge_settle();
        check("hold_clear_clk_running", 8'h00);

        // Release between edges with 3+4 waiting: 0 after edge 1, 7 after edge 2.
        @(negedge clk);
        io_A  = 8'd3;
        io_B  = 8'd4;
        reset = 1'b1;
        edge_settle();
        check("first_edge_after_release", 8'd0);
        edge_settle();
        check("first_sum_latency2", 8'd7);

        // Table stream: a new pair every cycle, each checked two edges later.
        for (int i = 0; i < 14; i++) begin
            if (i >= 2) check($sformatf("stream[%0d] %0d+%0d", i - 2, vecs[i-2].a, vecs[i-2].b), vecs[i-2].x);
            if (i < 12) begin
                io_A = vecs[i].a;
                io_B = vecs[i].b;
            end else begin
                io_A = 8'd0;
                io_B = 8'd0;
            end
            edge_settle();
        end

        // Mid-stream reset with 10+20 in flight.
        io_A = 8'd10;
        io_B = 8'd20;
        edge_settle();
        edge_settle();
        check("pre_reset_sum", 8'd30);
        @(negedge clk);
        io_A  = 8'd0;
        io_B  = 8'd0;
        reset = 1'b0;
        #1;
        check("midstream_async_clear", 8'd0);
        repeat (2) edge_settle();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_settle();
            check($sformatf("post_reset_no_stale[%0d]", i), 8'd0);
        end

        // Inputs toggled between edges: only the values at each edge count.
        io_A = 8'd5;
        io_B = 8'd6;
        #2;
        io_A = 8'd50;
        io_B = 8'd60;
        edge_settle();
        io_A = 8'd9;
        io_B = 8'd9;
        #2;
        io_A = 8'd1;
        io_B = 8'd2;
        edge_settle();
        io_A = 8'd0;
        io_B = 8'd0;
        check("toggle_sample1", 8'd110);
        #3;
        check("toggle_no_glitch", 8'd110);
        edge_settle();
        check("toggle_sample2", 8'd3);

        // Held operands give a constant output.
        io_A = 8'd7;
        io_B = 8'd8;
        repeat (2) edge_settle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_const[%0d]", i), 8'd15);
            edge_settle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_my_top_level

// File: doc/my_top_level.md
MY_TOP_LEVEL -- requirements
Module: my_top_level

Interface
REQ-001 Parameter: WIDTH, default 8, data width of io_A, io_B and io_X.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = in reset), despite the port name.
REQ-004 Port: io_A  input  WIDTH  first unsigned addend.
REQ-005 Port: io_B  input  WIDTH  second unsigned addend.
REQ-006 Port: io_X  output  WIDTH  registered sum; driven directly from a flop, no combinational path from inputs.

Function
REQ-007 The block SHALL compute io_X = (io_A + io_B) mod 2^WIDTH on unsigned operands; the carry-out SHALL be discarded, with no overflow flag.
REQ-008 The block SHALL have a two-stage pipeline: stage 1 registers io_A/io_B every rising clk edge; stage 2 registers the sum of the stage-1 values.
REQ-009 Latency SHALL be exactly 2 clk rising edges: operands present before edge N appear on io_X after edge N+1.
REQ-010 Throughput SHALL be one result per cycle: new operands every cycle with no stalls and no handshake.
REQ-011 Operands held constant SHALL give a constant io_X after 2 edges; io_X SHALL NOT glitch between edges.
REQ-012 Wrap-around: 255+1 SHALL yield 0, and 255+255 SHALL yield 254 (WIDTH=8).
REQ-013 Input changes between clock edges SHALL have no effect on io_X until the next sampling edge.

Reset
REQ-014 When reset = 0, all stage-1 and stage-2 registers SHALL clear to 0 immediately, without waiting for a clk edge; io_X = 0.
REQ-015 While reset = 0, io_X SHALL stay 0 regardless of clk activity or input values, including with clk stopped.
REQ-016 After reset rises, the first rising edge SHALL sample operands; the first valid sum SHALL appear after the second edge. io_X SHALL read 0 (reset value + reset value) after the first edge.
REQ-017 Reset asserted mid-stream SHALL discard all in-flight operands; no pre-reset result SHALL appear after release.

Structure
REQ-018 Package my_top_level_pkg SHALL hold the default WIDTH constant (8) and the reset-active level constant (1'b0).
REQ-019 One sub-module, my_top_level_add_stage, SHALL implement a single registered WIDTH-bit modular add with async active-low clear. The top SHALL hold the input register stage and one instance of it.
REQ-020 The block SHALL contain no latches, no initial-value reliance, and no second clock domain.

Verification
REQ-021 reset=0 with clk stopped, io_A=0x12, io_B=0x34 -> io_X=0x00 held indefinitely.
REQ-022 After release, io_A=3, io_B=4 applied before edge 1 -> io_X=7 after edge 2, and not before.
REQ-023 Wrap: 200+100 -> 44; 255+1 -> 0; 255+255 -> 254, each 2 edges after application.
REQ-024 Back-to-back stream (1+1, 2+2, 3+3, 4+4) on consecutive edges -> io_X 2, 4, 6, 8 on consecutive cycles, starting 2 edges after the first operand pair.
REQ-025 Reset pulled low between edges while 10+20 is in flight -> io_X=0 at once. After release with inputs 0+0, io_X never shows 30.
REQ-026 Operands toggled between edges (setup respected at the edges) -> io_X reflects only the values present at each sampling edge.
